// File: rtl/io_port_unit_pkg.sv
// io_port_unit_pkg: shared widths and interrupt FSM state encodings for the I/O port unit
package io_port_unit_pkg;
    localparam int IO_DATA_W = 16;
    typedef enum logic [1:0] {
        IO_INT_IDLE = 2'd0,
        IO_INT_FIRE = 2'd1,
        IO_INT_GAP  = 2'd2
    } int_state_e;
endpackage

// File: rtl/io_port_unit_if.sv
// io_port_unit_if: core/external-side signal bundle of the I/O port unit
interface io_port_unit_if
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] proc_in;
    logic              in_rd;
    logic              in_empty;
    logic [CW-1:0]     in_count;
    logic [DATA_W-1:0] proc_out;
    logic              out_wr;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [CW-1:0]     out_count;
    logic              out_overflow;
    logic              int_req;
    logic              Int;
    modport slave (
        input  ext_in_data, ext_in_valid, in_rd, proc_out, out_wr, ext_out_ready, int_req,
        output ext_in_ready, proc_in, in_empty, in_count, ext_out_data, ext_out_valid,
               out_count, out_overflow, Int
    );
    modport master (
        output ext_in_data, ext_in_valid, in_rd, proc_out, out_wr, ext_out_ready, int_req,
        input  ext_in_ready, proc_in, in_empty, in_count, ext_out_data, ext_out_valid,
               out_count, out_overflow, Int
    );
endinterface

// File: rtl/io_port_unit_fifo.sv
// io_fifo: DEPTH-entry FIFO; a write while full is taken only when the head pops the same cycle
module io_fifo
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    wr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    rd,
    output logic [DATA_W-1:0]       rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign pop   = rd && !empty;
    assign push  = wr && (!full || pop);
    assign rdata = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: input/output FIFOs between core In/Out ports and the outside, plus interrupt pulse conditioning
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W  = IO_DATA_W,
    parameter int DEPTH   = 4,
    parameter int INT_GAP = 4
) (
    input logic          Clk,
    input logic          Rst,
    io_port_unit_if.slave bus
);
    localparam int GW = $clog2(INT_GAP + 1);
    logic       in_full, out_full, out_empty;
    logic       req_q, rise, pending, pending_n, int_q;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    int_state_e state, state_n;
    // Input side must not accept while full even if the core pops, so ready stays free of in_rd.
    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in (
        .Clk(Clk), .Rst(Rst), .wr(bus.ext_in_valid && !in_full), .wdata(bus.ext_in_data),
        .rd(bus.in_rd), .rdata(bus.proc_in), .full(in_full), .empty(bus.in_empty),
        .count(bus.in_count)
    );
    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out (
        .Clk(Clk), .Rst(Rst), .wr(bus.out_wr), .wdata(bus.proc_out),
        .rd(bus.ext_out_ready), .rdata(bus.ext_out_data), .full(out_full), .empty(out_empty),
        .count(bus.out_count)
    );
    assign bus.ext_in_ready  = !in_full;
    assign bus.ext_out_valid = !out_empty;
    assign bus.Int           = int_q;
    assign rise              = bus.int_req && !req_q;
    always_ff @(posedge Clk) begin
        if (Rst) bus.out_overflow <= 1'b0;
        else if (bus.out_wr && out_full && !bus.ext_out_ready) bus.out_overflow <= 1'b1;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IO_INT_IDLE;
            gap_cnt <= '0;
            pending <= 1'b0;
            req_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_cnt_n;
            pending <= pending_n;
            req_q   <= bus.int_req;
            int_q   <= state_n == IO_INT_FIRE;
        end
    end
    // GAP ends one cycle early so the IDLE cycle completes the INT_GAP idle cycles.
    always_comb begin
        state_n   = state;
        gap_cnt_n = gap_cnt;
        pending_n = pending || rise;
        case (state)
            IO_INT_IDLE: begin
                state_n   = (rise || pending) ? IO_INT_FIRE : IO_INT_IDLE;
                pending_n = 1'b0;
            end
            IO_INT_FIRE: begin
                state_n   = IO_INT_GAP;
                gap_cnt_n = GW'(INT_GAP - 1);
            end
            IO_INT_GAP: begin
                gap_cnt_n = gap_cnt - GW'(1);
                state_n   = (gap_cnt <= GW'(1)) ? IO_INT_IDLE : IO_INT_GAP;
            end
            default: state_n = IO_INT_IDLE;
        endcase
    end
endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed stimulus with queued expectations checked by an independent negedge monitor
module tb_io_port_unit;
    import io_port_unit_pkg::*;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int G  = 4;
    typedef struct {
        int          c;
        int          s;
        logic [31:0] v;
    } chk_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    chk_t        chk_q[$];
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    int          int_q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    io_port_unit_if #(.DATA_W(DW), .DEPTH(D)) bus();
    io_port_unit #(.DATA_W(DW), .DEPTH(D), .INT_GAP(G)) dut (.Clk(clk), .Rst(rst), .bus(bus));

    function automatic string sig_name(int s);
        case (s)
            0: return "in_count";
            1: return "ext_in_ready";
            2: return "proc_in";
            3: return "in_empty";
            4: return "out_count";
            5: return "out_overflow";
            6: return "ext_out_data";
            7: return "Int";
            default: return "ext_out_valid";
        endcase
    endfunction
    function automatic logic [31:0] sig_val(int s);
        case (s)
            0: return 32'(bus.in_count);
            1: return 32'(bus.ext_in_ready);
            2: return 32'(bus.proc_in);
            3: return 32'(bus.in_empty);
            4: return 32'(bus.out_count);
            5: return 32'(bus.out_overflow);
            6: return 32'(bus.ext_out_data);
            7: return 32'(bus.Int);
            default: return 32'(bus.ext_out_valid);
        endcase
    endfunction
    task automatic cmp(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
        end
    endtask
    task automatic unexpected(string nm, logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s cyc=%0d got=%0h want=none", nm, cyc, act);
    endtask
    task automatic exp(int s, logic [31:0] v);
        chk_q.push_back('{c: cyc, s: s, v: v});
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk_t e;
        while (chk_q.size() > 0 && chk_q[0].c <= cyc) begin
            e = chk_q.pop_front();
            cmp(sig_name(e.s), sig_val(e.s), e.v);
        end
        if (bus.in_rd && !bus.in_empty) begin
            if (in_q.size() == 0) unexpected("proc_in_pop", 32'(bus.proc_in));
            else cmp("proc_in_pop", 32'(bus.proc_in), 32'(in_q.pop_front()));
        end
        if (bus.ext_out_valid && bus.ext_out_ready) begin
            if (out_q.size() == 0) unexpected("ext_out_pop", 32'(bus.ext_out_data));
            else cmp("ext_out_pop", 32'(bus.ext_out_data), 32'(out_q.pop_front()));
        end
        while (int_q.size() > 0 && int_q[0] < cyc) cmp("int_missed", 32'(cyc), 32'(int_q.pop_front()));
        if (bus.Int) begin
            if (int_q.size() == 0) unexpected("int_pulse", 32'(cyc));
            else cmp("int_pulse", 32'(cyc), 32'(int_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int m;
        bus.ext_in_data = '0; bus.ext_in_valid = 0; bus.in_rd = 0;
        bus.proc_out = '0; bus.out_wr = 0; bus.ext_out_ready = 0; bus.int_req = 0;
        step(); step();
        rst = 0;
        exp(0, 0); exp(1, 1); exp(2, 0); exp(3, 1); exp(4, 0); exp(5, 0); exp(6, 0); exp(7, 0); exp(8, 0);
        for (int i = 0; i < 4; i++) begin
            bus.ext_in_valid = 1; bus.ext_in_data = w[i];
            in_q.push_back(w[i]);
            step();
            exp(0, i + 1); exp(2, 32'h1111);
        end
        exp(1, 0);
        bus.ext_in_data = 16'h5555;
        step();
        bus.ext_in_valid = 0;
        exp(0, 4); exp(1, 0); exp(2, 32'h1111);
        bus.in_rd = 1;
        repeat (4) step();
        exp(0, 0); exp(2, 0); exp(3, 1); exp(1, 1);
        step();
        bus.in_rd = 0;
        exp(0, 0); exp(3, 1);
        for (int i = 0; i < 2; i++) begin
            bus.ext_in_valid = 1; bus.ext_in_data = 16'(16'h7777 + i * 16'h1111);
            in_q.push_back(bus.ext_in_data);
            step();
        end
        bus.ext_in_data = 16'h9999; in_q.push_back(16'h9999);
        bus.in_rd = 1;
        step();
        bus.ext_in_valid = 0; bus.in_rd = 0;
        exp(0, 2); exp(2, 32'h8888);
        bus.in_rd = 1;
        repeat (2) step();
        bus.in_rd = 0;
        exp(0, 0);
        for (int i = 0; i < 5; i++) begin
            bus.out_wr = 1; bus.proc_out = 16'(16'hA001 + i);
            if (i < 4) out_q.push_back(bus.proc_out);
            exp(5, 0);
            step();
            exp(4, (i < 4) ? i + 1 : 4);
        end
        exp(5, 1); exp(6, 32'hA001); exp(8, 1);
        bus.proc_out = 16'hBEEF; bus.ext_out_ready = 1;
        out_q.push_back(16'hBEEF);
        step();
        bus.out_wr = 0;
        exp(4, 4); exp(5, 1); exp(6, 32'hA002);
        repeat (4) step();
        bus.ext_out_ready = 0;
        exp(8, 0); exp(6, 0); exp(4, 0); exp(5, 1);
        m = cyc;
        int_q.push_back(m + 1);
        bus.int_req = 1; step();
        bus.int_req = 0; step();
        int_q.push_back(m + 6);
        bus.int_req = 1; step();
        bus.int_req = 0; step();
        bus.int_req = 1; step();
        bus.int_req = 0;
        repeat (12) step();
        bus.ext_in_valid = 1; bus.ext_in_data = 16'h1234; step();
        bus.ext_in_data = 16'h5678; step();
        bus.ext_in_valid = 0;
        exp(0, 2);
        m = cyc;
        int_q.push_back(m + 1);
        bus.int_req = 1; step();
        bus.int_req = 0; step();
        bus.int_req = 1; step();
        bus.int_req = 0; rst = 1; step();
        rst = 0;
        exp(0, 0); exp(2, 0); exp(3, 1); exp(7, 0); exp(5, 0);
        repeat (12) step();
        cmp("chk_q_left", 32'(chk_q.size()), 0);
        cmp("int_q_left", 32'(int_q.size()), 0);
        cmp("out_q_left", 32'(out_q.size()), 0);
        cmp("in_q_left", 32'(in_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
